// File: rtl/rs_entry_allocator_pkg.sv
// Shared scheduler types for the reservation-station entry pool.
package rs_entry_allocator_pkg;

    localparam int unsigned RS_ENTRIES = 16;
    localparam int unsigned RS_IDX_W   = $clog2(RS_ENTRIES);
    localparam int unsigned RS_CNT_W   = $clog2(RS_ENTRIES) + 1;

    typedef logic [RS_IDX_W-1:0]   rs_idx_t;
    typedef logic [RS_ENTRIES-1:0] rs_mask_t;

    typedef enum logic {
        RS_RUN   = 1'b0,
        RS_FLUSH = 1'b1
    } rs_alloc_state_t;

endpackage

// File: rtl/rs_free_pick.sv
// Combinational lowest-zero finder over an entry-valid mask.
module rs_free_pick #(
    parameter  int unsigned N     = rs_entry_allocator_pkg::RS_ENTRIES,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest free index is written last and wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_entry_allocator.sv
// Reservation-station entry pool: grants one free entry per cycle to dispatch,
// returns entries on issue, and clears the pool on flush.
module rs_entry_allocator #(
    parameter  int unsigned RS_ENTRIES = rs_entry_allocator_pkg::RS_ENTRIES,
    parameter  int unsigned AF_MARGIN  = 2,
    localparam int unsigned IDX_W      = $clog2(RS_ENTRIES),
    localparam int unsigned CNT_W      = $clog2(RS_ENTRIES) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  disp_valid,
    output logic                  disp_ready,
    output logic                  alloc_fire,
    output logic [IDX_W-1:0]      alloc_entry,
    input  logic                  issue_valid,
    input  logic [IDX_W-1:0]      issue_entry,
    input  logic                  flush,
    output logic [RS_ENTRIES-1:0] valid_mask,
    output logic [CNT_W-1:0]      occupancy,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  err_bad_free
);

    import rs_entry_allocator_pkg::*;

    rs_alloc_state_t       state;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic                  running;
    logic                  issue_ok;
    logic                  legal_free;
    logic                  bad_free;
    logic [RS_ENTRIES-1:0] mask_next;
    logic [CNT_W-1:0]      occ_next;
    logic [CNT_W-1:0]      free_cnt;

    rs_free_pick #(
        .N (RS_ENTRIES)
    ) u_free_pick (
        .mask  (valid_mask),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Status flags decoded purely from the registered occupancy.
    assign free_cnt    = CNT_W'(RS_ENTRIES) - occupancy;
    assign full        = (occupancy == CNT_W'(RS_ENTRIES));
    assign empty       = (occupancy == '0);
    assign almost_full = (free_cnt <= CNT_W'(AF_MARGIN));

    // Dispatch handshake; an entry freed this cycle is not visible until the next.
    assign running     = (state == RS_RUN);
    assign alloc_entry = pick_found ? pick_idx : '0;
    assign disp_ready  = rst && running && !full && !flush;
    assign alloc_fire  = disp_valid && disp_ready;

    // Issue qualification: ignored during reset, flush, and the FLUSH state.
    assign issue_ok   = rst && running && !flush && issue_valid;
    assign legal_free = issue_ok && valid_mask[issue_entry];
    assign bad_free   = issue_ok && !valid_mask[issue_entry];

    // Next mask and occupancy from one allocation and at most one legal free.
    always_comb begin
        mask_next = valid_mask;
        if (alloc_fire) begin
            mask_next[alloc_entry] = 1'b1;
        end
        if (legal_free) begin
            mask_next[issue_entry] = 1'b0;
        end
        occ_next = occupancy + CNT_W'(alloc_fire) - CNT_W'(legal_free);
    end

    // RUN/FLUSH controller with pool state and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= RS_RUN;
            valid_mask   <= '0;
            occupancy    <= '0;
            err_bad_free <= 1'b0;
        end else begin
            case (state)
                RS_RUN: begin
                    if (flush) begin
                        state      <= RS_FLUSH;
                        valid_mask <= '0;
                        occupancy  <= '0;
                    end else begin
                        valid_mask <= mask_next;
                        occupancy  <= occ_next;
                        if (bad_free) begin
                            err_bad_free <= 1'b1;
                        end
                    end
                end
                RS_FLUSH: begin
                    valid_mask <= '0;
                    occupancy  <= '0;
                    state      <= flush ? RS_FLUSH : RS_RUN;
                end
                default: begin
                    state      <= RS_RUN;
                    valid_mask <= '0;
                    occupancy  <= '0;
                end
            endcase
        end
    end

    function automatic logic [CNT_W-1:0] popcount(input logic [RS_ENTRIES-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            c = c + CNT_W'(m[i]);
        end
        return c;
    endfunction

    // Occupancy counter must always agree with the number of set mask bits.
    always @(posedge clk) begin
        if (rst) begin
            assert (occupancy == popcount(valid_mask));
        end
    end

endmodule

// File: tb/tb_rs_entry_allocator.sv
// Directed self-checking bench for rs_entry_allocator (8 entries, margin 2).
module tb_rs_entry_allocator;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned CNT_W = $clog2(N) + 1;

    logic             clk;
    logic             rst;
    logic             disp_valid;
    logic             disp_ready;
    logic             alloc_fire;
    logic [IDX_W-1:0] alloc_entry;
    logic             issue_valid;
    logic [IDX_W-1:0] issue_entry;
    logic             flush;
    logic [N-1:0]     valid_mask;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             err_bad_free;

    int vectors;
    int miscompares;

    rs_entry_allocator #(
        .RS_ENTRIES (N),
        .AF_MARGIN  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .alloc_fire   (alloc_fire),
        .alloc_entry  (alloc_entry),
        .issue_valid  (issue_valid),
        .issue_entry  (issue_entry),
        .flush        (flush),
        .valid_mask   (valid_mask),
        .occupancy    (occupancy),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .err_bad_free (err_bad_free)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge so registered outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        disp_valid  = 1'b1;
        issue_valid = 1'b0;
        issue_entry = '0;
        flush       = 1'b0;

        // Reset: held low for two edges with dispatch requesting.
        tick();
        tick();
        chk("rst_disp_ready", 32'(disp_ready), 32'd0);
        chk("rst_alloc_fire", 32'(alloc_fire), 32'd0);
        chk("rst_mask", 32'(valid_mask), 32'h00);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_err", 32'(err_bad_free), 32'd0);

        // Fill the pool in order.
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            disp_valid = 1'b1;
            #1;
            chk("fill_entry", 32'(alloc_entry), 32'(i));
            chk("fill_fire", 32'(alloc_fire), 32'd1);
            chk("fill_af", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
            tick();
        end
        #1;
        chk("full_flag", 32'(full), 32'd1);
        chk("full_ready", 32'(disp_ready), 32'd0);
        chk("full_fire", 32'(alloc_fire), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd8);
        chk("full_mask", 32'(valid_mask), 32'hFF);

        // Issue from a full pool: freed entry is only allocatable a cycle later.
        issue_valid = 1'b1;
        issue_entry = 3'd3;
        #1;
        chk("nobypass_ready", 32'(disp_ready), 32'd0);
        tick();
        issue_valid = 1'b0;
        #1;
        chk("refill_ready", 32'(disp_ready), 32'd1);
        chk("refill_entry", 32'(alloc_entry), 32'd3);
        chk("refill_occ_mid", 32'(occupancy), 32'd7);
        chk("refill_mask_mid", 32'(valid_mask), 32'hF7);
        tick();
        disp_valid = 1'b0;
        #1;
        chk("refill_occ", 32'(occupancy), 32'd8);
        chk("refill_full", 32'(full), 32'd1);

        // Clear via flush, then build occupancy 4 (entries 0-3).
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        disp_valid = 1'b1;
        repeat (4) tick();

        // Simultaneous allocate and legal issue.
        issue_valid = 1'b1;
        issue_entry = 3'd1;
        #1;
        chk("simul_entry", 32'(alloc_entry), 32'd4);
        tick();
        disp_valid  = 1'b0;
        issue_valid = 1'b0;
        #1;
        chk("simul_mask", 32'(valid_mask), 32'h1D);
        chk("simul_occ", 32'(occupancy), 32'd4);
        chk("simul_err", 32'(err_bad_free), 32'd0);

        // Empty pool, issue to an unoccupied entry.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        issue_valid = 1'b1;
        issue_entry = 3'd5;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("bad_err", 32'(err_bad_free), 32'd1);
        chk("bad_occ", 32'(occupancy), 32'd0);
        chk("bad_mask", 32'(valid_mask), 32'h00);
        tick();
        tick();
        chk("bad_err_sticky", 32'(err_bad_free), 32'd1);

        // Occupancy 6, then flush with dispatch and issue in the same cycle.
        disp_valid = 1'b1;
        repeat (6) tick();
        chk("pre_flush_occ", 32'(occupancy), 32'd6);
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_entry = 3'd2;
        #1;
        chk("flush_fire", 32'(alloc_fire), 32'd0);
        chk("flush_ready", 32'(disp_ready), 32'd0);
        tick();
        flush       = 1'b0;
        issue_valid = 1'b0;
        #1;
        chk("flushst_mask", 32'(valid_mask), 32'h00);
        chk("flushst_occ", 32'(occupancy), 32'd0);
        chk("flushst_ready", 32'(disp_ready), 32'd0);
        chk("flushst_fire", 32'(alloc_fire), 32'd0);
        chk("flushst_err", 32'(err_bad_free), 32'd1);
        tick();
        disp_valid = 1'b0;
        #1;
        chk("postflush_ready", 32'(disp_ready), 32'd1);
        chk("postflush_entry", 32'(alloc_entry), 32'd0);

        // Flush held for two cycles keeps the block in FLUSH.
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        #1;
        chk("dflush_ready", 32'(disp_ready), 32'd0);
        tick();
        chk("dflush_exit_ready", 32'(disp_ready), 32'd1);

        // Reset while in FLUSH (flush still high at the reset edge).
        flush = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rstfl_ready_low", 32'(disp_ready), 32'd0);
        rst   = 1'b1;
        flush = 1'b0;
        #1;
        chk("rstfl_ready", 32'(disp_ready), 32'd1);
        chk("rstfl_err", 32'(err_bad_free), 32'd0);
        chk("rstfl_empty", 32'(empty), 32'd1);
        chk("rstfl_occ", 32'(occupancy), 32'd0);
        chk("rstfl_mask", 32'(valid_mask), 32'h00);
        chk("rstfl_entry", 32'(alloc_entry), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
